// File: rtl/regfile_arb_pkg.sv
// Shared defaults, arbiter state encoding and conflict-counter helpers for the
// register-file write arbiter.
package regfile_arb_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SIZE_DEF  = 5;
  localparam int CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two write-request channels, the register-file write port and
// the read-data path between requesters, arbiter and register file.
interface regfile_write_arbiter_if #(
  parameter int WIDTH = regfile_arb_pkg::WIDTH_DEF,
  parameter int SIZE  = regfile_arb_pkg::SIZE_DEF
);
  logic             req0_valid_i;
  logic             req1_valid_i;
  logic [SIZE-1:0]  req0_addr_i;
  logic [SIZE-1:0]  req1_addr_i;
  logic [WIDTH-1:0] req0_data_i;
  logic [WIDTH-1:0] req1_data_i;
  logic             req0_ready_o;
  logic             req1_ready_o;
  logic             reg_write_o;
  logic [SIZE-1:0]  write_register_o;
  logic [WIDTH-1:0] write_data_o;
  logic [SIZE-1:0]  read_register_1_i;
  logic [SIZE-1:0]  read_register_2_i;
  logic [WIDTH-1:0] rf_read_data_1_i;
  logic [WIDTH-1:0] rf_read_data_2_i;
  logic [WIDTH-1:0] read_data_1_o;
  logic [WIDTH-1:0] read_data_2_o;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req1_valid_i, req0_addr_i, req1_addr_i,
    input  req0_data_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output reg_write_o, write_register_o, write_data_o,
    input  read_register_1_i, read_register_2_i,
    input  rf_read_data_1_i, rf_read_data_2_i,
    output read_data_1_o, read_data_2_o
  );

  // Requester / register-file side
  modport master (
    output req0_valid_i, req1_valid_i, req0_addr_i, req1_addr_i,
    output req0_data_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  reg_write_o, write_register_o, write_data_o,
    output read_register_1_i, read_register_2_i,
    output rf_read_data_1_i, rf_read_data_2_i,
    input  read_data_1_o, read_data_2_o
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant logic with its priority state register.
// state | meaning
// PRI0  | requester 0 wins a tie
// PRI1  | requester 1 wins a tie
module rr_arbiter_2
  import regfile_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);
  arb_state_t r_state;
  arb_state_t w_state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= PRI0;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_gnt0      = 1'b0;
    o_gnt1      = 1'b0;
    if (i_en) begin
      if (i_req0 && (!i_req1 || r_state == PRI0)) o_gnt0 = 1'b1;
      else if (i_req1)                             o_gnt1 = 1'b1;
    end
    if (o_gnt0)      w_state_nxt = PRI1;
    else if (o_gnt1) w_state_nxt = PRI0;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging two write requesters onto one register-file write port.
// Define RF_WB_FORWARD_EN to forward the registered write data onto the read ports.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SIZE  = SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  output logic [CNT_W-1:0]  conflict_cnt_o,
  regfile_write_arbiter_if.slave bus
);
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic             w_conflict;
  logic [SIZE-1:0]  w_addr;
  logic [WIDTH-1:0] w_data;

  logic             r_reg_write;
  logic [SIZE-1:0]  r_wr_reg;
  logic [WIDTH-1:0] r_wr_data;
  logic [CNT_W-1:0] r_conflict;

  // Reset gates the grant so readies drop the moment reset asserts.
  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_en   (reset && !hold_i),
    .i_req0 (bus.req0_valid_i),
    .i_req1 (bus.req1_valid_i),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign bus.req0_ready_o = w_gnt0;
  assign bus.req1_ready_o = w_gnt1;

  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_conflict = bus.req0_valid_i & bus.req1_valid_i;
  assign w_addr     = w_gnt1 ? bus.req1_addr_i : bus.req0_addr_i;
  assign w_data     = w_gnt1 ? bus.req1_data_i : bus.req0_data_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_conflict  <= '0;
    end else begin
      r_reg_write <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_wr_reg  <= w_addr;
        r_wr_data <= w_data;
      end
      if (w_conflict) r_conflict <= sat_inc(r_conflict);
    end
  end

  assign bus.reg_write_o      = r_reg_write;
  assign bus.write_register_o = r_wr_reg;
  assign bus.write_data_o     = r_wr_data;
  assign conflict_cnt_o       = r_conflict;

`ifdef RF_WB_FORWARD_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = r_reg_write && (bus.read_register_1_i == r_wr_reg) &&
                  (bus.read_register_1_i != '0);
  assign w_fwd2 = r_reg_write && (bus.read_register_2_i == r_wr_reg) &&
                  (bus.read_register_2_i != '0);
  assign bus.read_data_1_o = w_fwd1 ? r_wr_data : bus.rf_read_data_1_i;
  assign bus.read_data_2_o = w_fwd2 ? r_wr_data : bus.rf_read_data_2_i;
`else
  logic w_unused_rd_addr;

  assign bus.read_data_1_o = bus.rf_read_data_1_i;
  assign bus.read_data_2_o = bus.rf_read_data_2_i;
  assign w_unused_rd_addr  = ^{bus.read_register_1_i, bus.read_register_2_i};
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed literal checks plus random traffic
// compared every cycle against a transaction-level model.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold_i = 1'b0;
  logic [15:0] conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter_if #(.WIDTH(32), .SIZE(5)) bus ();

  regfile_write_arbiter #(.WIDTH(32), .SIZE(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .hold_i         (hold_i),
    .conflict_cnt_o (conflict_cnt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Model state: who wins the next tie, and what the write port shows now.
  logic        m_pri1;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic [31:0] rf);
`ifdef RF_WB_FORWARD_EN
    if (m_we && ra == m_wa && ra != 5'd0) return m_wd;
`endif
    return rf;
  endfunction

  always @(negedge clk) begin
    logic e_g0, e_g1;
    logic [4:0] a;
    logic [31:0] d;
    if (!reset) begin
      m_pri1 = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_cnt = 0;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (reset && !hold_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        e_g1 = m_pri1;
        e_g0 = !m_pri1;
      end else begin
        e_g0 = bus.req0_valid_i;
        e_g1 = bus.req1_valid_i;
      end
    end
    chk("ready0", bus.req0_ready_o, e_g0);
    chk("ready1", bus.req1_ready_o, e_g1);
    chk("reg_write", bus.reg_write_o, m_we);
    chk("write_register", bus.write_register_o, m_wa);
    chk("write_data", bus.write_data_o, m_wd);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("read_data_1", bus.read_data_1_o, exp_rd(bus.read_register_1_i, bus.rf_read_data_1_i));
    chk("read_data_2", bus.read_data_2_o, exp_rd(bus.read_register_2_i, bus.rf_read_data_2_i));
    if (reset) begin
      a = e_g1 ? bus.req1_addr_i : bus.req0_addr_i;
      d = e_g1 ? bus.req1_data_i : bus.req0_data_i;
      m_we = (e_g0 || e_g1) && a != 5'd0;
      if (e_g0 || e_g1) begin
        m_wa = a;
        m_wd = d;
      end
      if (e_g0) m_pri1 = 1'b1;
      if (e_g1) m_pri1 = 1'b0;
      if (bus.req0_valid_i && bus.req1_valid_i && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    bus.req0_addr_i = '0;    bus.req1_addr_i = '0;
    bus.req0_data_i = '0;    bus.req1_data_i = '0;
    bus.read_register_1_i = '0; bus.read_register_2_i = '0;
    bus.rf_read_data_1_i = '0;  bus.rf_read_data_2_i = '0;
    hold_i = 1'b0;
  endtask

  initial begin
    logic acc0, acc1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_cnt", conflict_cnt, 0);
    chk("lit_rst_we", bus.reg_write_o, 0);
    chk("lit_rst_wa", bus.write_register_o, 0);
    chk("lit_rst_wd", bus.write_data_o, 0);

    // Single requester 0
    cyc(); bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd2; bus.req0_data_i = 32'd7;
    @(negedge clk); chk("lit_r0_ready", bus.req0_ready_o, 1);
    cyc(); bus.req0_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_r0_we", bus.reg_write_o, 1);
    chk("lit_r0_wa", bus.write_register_o, 2);
    chk("lit_r0_wd", bus.write_data_o, 7);
    cyc(); @(negedge clk); chk("lit_r0_we_drop", bus.reg_write_o, 0);

    // Requester 1 writing register 0: handshake happens, no write
    cyc(); bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd0; bus.req1_data_i = 32'd78;
    @(negedge clk); chk("lit_a0_ready", bus.req1_ready_o, 1);
    cyc(); bus.req1_valid_i = 1'b0;
    @(negedge clk); chk("lit_a0_we", bus.reg_write_o, 0);

    // Both valid for four cycles: alternation starting with requester 0
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd4;  bus.req0_data_i = 32'd20;
      bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd31; bus.req1_data_i = 32'd6;
      @(negedge clk);
      chk("lit_alt_ready0", bus.req0_ready_o, (i % 2 == 0));
      chk("lit_alt_ready1", bus.req1_ready_o, (i % 2 == 1));
      if (i > 0) chk("lit_alt_wa", bus.write_register_o, (i % 2 == 1) ? 4 : 31);
    end
    cyc(); bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_alt_last_wa", bus.write_register_o, 31);
    chk("lit_alt_last_wd", bus.write_data_o, 6);
    chk("lit_alt_cnt", conflict_cnt, 4);

    // Write reg 19 then read it back while the write is on the port
    cyc(); bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd19; bus.req0_data_i = 32'd78;
    cyc(); bus.req0_valid_i = 1'b0;
    bus.read_register_2_i = 5'd19; bus.rf_read_data_2_i = 32'd0;
    @(negedge clk);
`ifdef RF_WB_FORWARD_EN
    chk("lit_fwd_rd2", bus.read_data_2_o, 78);
`else
    chk("lit_fwd_rd2", bus.read_data_2_o, 0);
`endif
    bus.read_register_2_i = '0;

    // Hold blocks grants but the conflict count still advances
    cyc(); hold_i = 1'b1; bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
    @(negedge clk);
    chk("lit_hold_ready0", bus.req0_ready_o, 0);
    chk("lit_hold_ready1", bus.req1_ready_o, 0);
    cyc(); idle_inputs();
    @(negedge clk);
    chk("lit_hold_cnt", conflict_cnt, 5);
    chk("lit_hold_we", bus.reg_write_o, 0);

    // Reset while a write sits on the port
    cyc(); bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd9; bus.req0_data_i = 32'd3;
    cyc(); bus.req0_valid_i = 1'b0;
    chk("lit_mid_we_before", bus.reg_write_o, 1);
    #1 reset = 1'b0;
    #1;
    chk("lit_mid_we_after", bus.reg_write_o, 0);
    chk("lit_mid_cnt_after", conflict_cnt, 0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    cyc();
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd4;
    bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd31;
    @(negedge clk);
    chk("lit_post_rst_ready0", bus.req0_ready_o, 1);
    chk("lit_post_rst_ready1", bus.req1_ready_o, 0);
    cyc(); idle_inputs();

    // Random traffic; requesters hold their request until accepted
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc0 = bus.req0_valid_i && bus.req0_ready_o;
      acc1 = bus.req1_valid_i && bus.req1_ready_o;
      cyc();
      if (!bus.req0_valid_i || acc0) begin
        bus.req0_valid_i = ($urandom_range(0, 2) != 0);
        bus.req0_addr_i  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 3));
        bus.req0_data_i  = $urandom;
      end
      if (!bus.req1_valid_i || acc1) begin
        bus.req1_valid_i = ($urandom_range(0, 2) != 0);
        bus.req1_addr_i  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 3));
        bus.req1_data_i  = $urandom;
      end
      hold_i = ($urandom_range(0, 7) == 0);
      bus.read_register_1_i = 5'($urandom_range(0, 3));
      bus.read_register_2_i = 5'($urandom_range(0, 3));
      bus.rf_read_data_1_i  = $urandom;
      bus.rf_read_data_2_i  = $urandom;
      if (n % 200 == 199) begin
        #1 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
      end
    end

    cyc(); idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of the register file.
REQ-002 Parameter SIZE, default 5, register address width (2**SIZE registers).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 hold_i  input  1  freeze; blocks all grants while high.
REQ-006 req0_valid_i / req1_valid_i  input  1  write request, requester 0 / 1.
REQ-007 req0_addr_i / req1_addr_i  input  SIZE  destination register.
REQ-008 req0_data_i / req1_data_i  input  WIDTH  write data.
REQ-009 req0_ready_o / req1_ready_o  output  1  grant; transfer when valid and ready are both high.
REQ-010 reg_write_o  output  1  to register file reg_write_i.
REQ-011 write_register_o  output  SIZE  to register file write_register_i.
REQ-012 write_data_o  output  WIDTH  to register file write_data_i.
REQ-013 read_register_1_i / read_register_2_i  input  SIZE  read addresses presented to the register file.
REQ-014 rf_read_data_1_i / rf_read_data_2_i  input  WIDTH  register file read_data outputs.
REQ-015 read_data_1_o / read_data_2_o  output  WIDTH  read data to consumers.
REQ-016 conflict_cnt_o  output  16  saturating count of cycles with both valids high.

Function
REQ-017 Arbiter SHALL be two-state round-robin: PRI0 (req0 wins ties), PRI1 (req1 wins ties).
REQ-018 Transitions: grant to req0 -> PRI1; grant to req1 -> PRI0; no grant -> hold state.
REQ-019 Single valid requester SHALL be granted the same cycle, regardless of state.
REQ-020 readyN_o SHALL be combinational, high only for the granted requester; at most one ready high per cycle.
REQ-021 hold_i high SHALL force both readies low; state and counter unchanged except conflict count.
REQ-022 Accepted request SHALL appear on reg_write_o/write_register_o/write_data_o exactly one cycle later (registered), for exactly one cycle.
REQ-023 Cycle with no transfer SHALL drive reg_write_o low next cycle; address/data hold previous values.
REQ-024 Transfer with address 0 SHALL complete the handshake and update state, but reg_write_o SHALL stay low (register 0 not written).
REQ-025 Requester SHALL hold valid, addr, data stable until accepted; arbiter does not buffer rejected requests.
REQ-026 conflict_cnt_o SHALL increment on every cycle with req0_valid_i and req1_valid_i both high (hold_i irrelevant), saturating at 16'hFFFF.
REQ-027 Throughput: one write per cycle; back-to-back alternation when both requesters stay valid.

Reset
REQ-028 reset low SHALL immediately set state PRI0, reg_write_o 0, write_register_o 0, write_data_o 0, conflict_cnt_o 0.
REQ-029 Readies SHALL be low while reset is low; a write registered before reset assertion SHALL be discarded.
REQ-030 First grant after release SHALL follow PRI0 priority.

Configuration
REQ-031 Macro RF_WB_FORWARD_EN defined: read_data_k_o SHALL equal write_data_o when reg_write_o high, read_register_k_i equals write_register_o, and read_register_k_i nonzero; else rf_read_data_k_i.
REQ-032 Macro undefined: read_data_k_o SHALL equal rf_read_data_k_i combinationally, no forwarding logic present.

Structure
REQ-033 Package regfile_arb_pkg SHALL hold WIDTH/SIZE defaults, arbiter state enum (PRI0, PRI1), counter width constant 16.
REQ-034 Sub-module rr_arbiter_2 SHALL contain the two-state round-robin grant logic and priority state register.

Verification
REQ-035 Reset low 3 cycles, release, no requests -> all outputs 0, reg_write_o 0, conflict_cnt_o 0.
REQ-036 req0 valid addr 2 data 7 alone -> req0_ready_o high same cycle; next cycle reg_write_o 1, write_register_o 2, write_data_o 7.
REQ-037 Both valid 4 cycles (req0 addr 4 data 20, req1 addr 31 data 6) -> grants req0,req1,req0,req1; outputs alternate; conflict_cnt_o 4.
REQ-038 req1 valid addr 0 data 78 -> ready high, reg_write_o stays 0, state moves to PRI0.
REQ-039 With RF_WB_FORWARD_EN: write reg 19 data 78 then read_register_2_i 19 while reg_write_o high, rf_read_data_2_i 0 -> read_data_2_o 78; without macro -> 0.
REQ-040 hold_i high with both valid -> both readies low, conflict_cnt_o increments; reset asserted mid-transfer -> reg_write_o 0 immediately.
